// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer owning the PC, with redirect/squash handling.
// Define FETCH_MISALIGN_CHK_EN to trap on misaligned redirect targets.
`ifndef INSTR_MEM_WIDTH
`define INSTR_MEM_WIDTH 32
`endif
module fetch_ctrl #(
   parameter int                ADDR_W   = `INSTR_MEM_WIDTH,
   parameter logic [ADDR_W-1:0] RESET_PC = 'h1000
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [ADDR_W-1:0] if_pc,
   output logic [31:0]       if_instr,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   output logic              fetch_err
);
`ifdef FETCH_MISALIGN_CHK_EN
   typedef enum logic [1:0] {IDLE, FETCH, DROP, TRAP} state_t;
`else
   typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;
`endif
   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, saved_target, new_target;
   logic              pending, hit, bad;
   assign imem_addr  = pc;
   assign hit        = imem_req && imem_ack;
   assign new_target = (redirect_valid ? redirect_target : saved_target) & ~ADDR_W'(3);
`ifdef FETCH_MISALIGN_CHK_EN
   assign bad = redirect_valid && (redirect_target[1:0] != 2'b00);
`else
   assign bad = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = FETCH;
         FETCH:   state_nxt = redirect_valid && imem_req && !imem_ack ? DROP : FETCH;
         DROP:    state_nxt = imem_ack ? FETCH : DROP;
         default: state_nxt = state;
      endcase
`ifdef FETCH_MISALIGN_CHK_EN
      if (bad && (state == FETCH || state == DROP)) state_nxt = TRAP;
`endif
   end
   // a request stays up until acked, so the pending term keeps imem_addr stable
   always_comb begin
      imem_req = state == DROP || (state == FETCH && (pending || !if_valid || if_ready));
`ifdef FETCH_MISALIGN_CHK_EN
      fetch_err = state == TRAP;
`else
      fetch_err = 1'b0;
`endif
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pc           <= RESET_PC;
         pending      <= 1'b0;
         saved_target <= '0;
         if_valid     <= 1'b0;
         if_pc        <= '0;
         if_instr     <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (redirect_valid) begin
                  if_valid <= 1'b0;
                  if (!bad && imem_req && !imem_ack) begin
                     saved_target <= redirect_target;
                     pending      <= 1'b1;
                  end else if (!bad) begin
                     pc      <= new_target;
                     pending <= 1'b0;
                  end
               end else if (hit) begin
                  if_instr <= imem_rdata;
                  if_pc    <= pc;
                  if_valid <= 1'b1;
                  pc       <= pc + ADDR_W'(4);
                  pending  <= 1'b0;
               end else begin
                  pending <= imem_req;
                  if (if_ready) if_valid <= 1'b0;
               end
            end
            DROP: begin
               if (redirect_valid) saved_target <= redirect_target;
               if (imem_ack && !bad) begin
                  pc      <= new_target;
                  pending <= 1'b0;
               end
            end
            default: pending <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench with an instruction scoreboard checked on each decode handshake.
module tb_fetch_ctrl;
   localparam int AW = 32;
   logic          clk = 1'b0, rst = 1'b1;
   logic          imem_req, imem_ack = 1'b1, if_valid, if_ready = 1'b1, redirect_valid = 1'b0, fetch_err;
   logic [AW-1:0] imem_addr, if_pc, redirect_target = '0;
   logic [31:0]   imem_rdata, if_instr;
   logic [AW-1:0] sb[$];
   int            checks = 0, errors = 0;
   always #5 clk = ~clk;
   function automatic logic [31:0] word(input logic [AW-1:0] a);
      return a * 32'd3 + 32'h1357;
   endfunction
   assign imem_rdata = word(imem_addr);
   fetch_ctrl #(.ADDR_W(AW), .RESET_PC(32'h1000)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
      .if_instr(if_instr), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .fetch_err(fetch_err)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input string t, input logic req_e, input logic [AW-1:0] addr_e,
                      input logic v_e, input logic err_e);
      @(negedge clk);
      chk({t, ".req"}, 32'(imem_req), 32'(req_e));
      chk({t, ".addr"}, imem_addr, addr_e);
      chk({t, ".valid"}, 32'(if_valid), 32'(v_e));
      chk({t, ".err"}, 32'(fetch_err), 32'(err_e));
      @(posedge clk); #1;
   endtask
   task automatic reset_chk(input string t);
      @(negedge clk);
      chk({t, ".req"}, 32'(imem_req), 0);
      chk({t, ".addr"}, imem_addr, 32'h1000);
      chk({t, ".valid"}, 32'(if_valid), 0);
      chk({t, ".if_pc"}, if_pc, 0);
      chk({t, ".if_instr"}, if_instr, 0);
      chk({t, ".err"}, 32'(fetch_err), 0);
      @(posedge clk); #1;
   endtask
   // every decode handshake must deliver the next expected fetch
   always @(negedge clk) begin
      if (!rst && if_valid && if_ready && !redirect_valid) begin
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL sb_empty observed_pc=%h expected=queued_entry", if_pc);
         end
         if (sb.size() > 0) begin
            logic [AW-1:0] e;
            e = sb.pop_front();
            chk("sb.if_pc", if_pc, e);
            chk("sb.if_instr", if_instr, word(e));
         end
      end
   end
   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset_chk("rst");
      rst = 1'b0;
      cyc("idle", 0, 32'h1000, 0, 0);
      sb.push_back(32'h1000); cyc("f0", 1, 32'h1000, 0, 0);
      sb.push_back(32'h1004); cyc("f1", 1, 32'h1004, 1, 0);
      sb.push_back(32'h1008); cyc("f2", 1, 32'h1008, 1, 0);
      if_ready = 1'b0;
      repeat (3) cyc("bp", 0, 32'h100C, 1, 0);
      if_ready = 1'b1; imem_ack = 1'b0;
      cyc("bp_rel", 1, 32'h100C, 1, 0);
      redirect_valid = 1'b1; redirect_target = 32'h2000;
      cyc("rd_pend", 1, 32'h100C, 0, 0);
      redirect_valid = 1'b0;
      cyc("drop", 1, 32'h100C, 0, 0);
      imem_ack = 1'b1;
      cyc("drop_ack", 1, 32'h100C, 0, 0);
      cyc("tgt", 1, 32'h2000, 0, 0);
      redirect_valid = 1'b1; redirect_target = 32'h2400;
      cyc("rd_ack", 1, 32'h2004, 1, 0);
      redirect_valid = 1'b0; imem_ack = 1'b0;
      cyc("tgt2", 1, 32'h2400, 0, 0);
      redirect_valid = 1'b1; redirect_target = 32'h2800;
      cyc("rd2", 1, 32'h2400, 0, 0);
      redirect_target = 32'h3000;
      cyc("rd3", 1, 32'h2400, 0, 0);
      redirect_valid = 1'b0; imem_ack = 1'b1;
      cyc("drop_ack2", 1, 32'h2400, 0, 0);
      cyc("tgt3", 1, 32'h3000, 0, 0);
      redirect_valid = 1'b1; redirect_target = 32'h3002;
      cyc("mis", 1, 32'h3004, 1, 0);
      redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      cyc("trap0", 0, 32'h3004, 0, 1);
      cyc("trap1", 0, 32'h3004, 0, 1);
`else
      cyc("mis_tgt", 1, 32'h3000, 0, 0);
`endif
      rst = 1'b1;
      @(posedge clk); #1;
      reset_chk("rst2");
      rst = 1'b0;
      cyc("idle2", 0, 32'h1000, 0, 0);
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFF8;
      cyc("rd_boot", 1, 32'h1000, 0, 0);
      redirect_valid = 1'b0;
      sb.push_back(32'hFFFF_FFF8); cyc("w0", 1, 32'hFFFF_FFF8, 0, 0);
      sb.push_back(32'hFFFF_FFFC); cyc("w1", 1, 32'hFFFF_FFFC, 1, 0);
      sb.push_back(32'h0000_0000); cyc("w2", 1, 32'h0000_0000, 1, 0);
      sb.push_back(32'h0000_0004); cyc("w3", 1, 32'h0000_0004, 1, 0);
      if_ready = 1'b0;
      cyc("bp2", 0, 32'h8, 1, 0);
      if_ready = 1'b1;
      cyc("bp2_rel", 1, 32'h8, 1, 0);
      if_ready = 1'b0;
      cyc("end", 0, 32'hC, 1, 0);
      chk("sb_drain", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
